// File: rtl/wwd_display_pkg.sv
// Shared definitions for the WWD display path: data word size,
// active-low seven-segment glyphs ({g,f,e,d,c,b,a}) and FSM encodings.
// No ports; imported by wwd_display and wwd_display_hex_to_seg.
package wwd_display_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/wwd_display_hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern ({g,f,e,d,c,b,a}).
// Latency: purely combinational. Backpressure: none.
// Ports: nibble (4-bit value in), seg (7-bit active-low pattern out).
module wwd_display_hex_to_seg
  import wwd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/wwd_display.sv
// WWD retirement sink: FIFO-buffers values, shows each for HOLD_CYCLES on a
// 4-digit multiplexed hex display, mirrors PC low byte onto LEDs.
// Latency: strobe to shown_value is 2 clocks from an idle, empty state.
// Backpressure: wwd_ready low while FIFO full; strobes then are dropped and set overflow.
// Ports: clk, reset_cpu (sync, active-high); wwd_valid/wwd_data/wwd_ready (CPU side);
// pc_below8bit -> led; seg/an (display, active-low); shown_value, pending, overflow (status).
module wwd_display
  import wwd_display_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int SCAN_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset_cpu,
  input  logic                         wwd_valid,
  input  logic [WORD_SIZE-1:0]         wwd_data,
  output logic                         wwd_ready,
  input  logic [7:0]                   pc_below8bit,
  output logic [7:0]                   led,
  output logic [6:0]                   seg,
  output logic [3:0]                   an,
  output logic [WORD_SIZE-1:0]         shown_value,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] mem_d [DEPTH];
  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [PW-1:0]        pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [WORD_SIZE-1:0] shown_q, shown_d;
  logic [7:0]           led_q, led_d;
  logic [SW-1:0]        scan_q, scan_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;

  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;
  logic [3:0]           digit_nibble;

  // No full-bypass: a pop in the same cycle does not open the FIFO to a push.
  assign wwd_ready     = (pending_q < PW'(DEPTH));
  assign push          = wwd_valid && wwd_ready;
  assign fifo_nonempty = (pending_q != '0);

  // Display sequencer: decides when the head entry moves onto the display.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (fifo_nonempty) begin
          // Back-to-back: next value replaces the current one with no gap.
          pop    = 1'b1;
          hold_d = HW'(HOLD_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pending_d  = pending_q;
    shown_d    = shown_q;
    overflow_d = overflow_q | (wwd_valid & ~wwd_ready);
    if (push) begin
      mem_d[tail_q] = wwd_data;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      shown_d = mem_q[head_q];
      head_d  = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  // Digit scan. an/seg are computed from the next index so both registers
  // always describe the same digit.
  always_comb begin
    led_d  = pc_below8bit;
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 1'b1;
    end
    an_d         = ~(4'b0001 << idx_d);
    digit_nibble = shown_q[{idx_d, 2'b00} +: 4];
  end

  wwd_display_hex_to_seg u_hex_to_seg (
    .nibble (digit_nibble),
    .seg    (seg_d)
  );

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      head_q     <= '0;
      tail_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      shown_q    <= '0;
      led_q      <= '0;
      scan_q     <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      shown_q    <= shown_d;
      led_q      <= led_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  // Storage needs no reset: entries are only read after being written,
  // and reset clears the pointers and occupancy.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign led         = led_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign shown_value = shown_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_wwd_display.sv
module tb_wwd_display;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic        wwd_valid;
  logic [15:0] wwd_data;
  logic        wwd_ready;
  logic [7:0]  pc_below8bit;
  logic [7:0]  led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] shown_value;
  logic [2:0]  pending;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sb[$];
  logic [15:0] last_shown = 16'h0000;
  bit          mon_en = 1'b0;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0][6:0] segs;   // expected glyph per digit index
  } vec_t;
  vec_t vecs[4];

  wwd_display #(.DEPTH(4), .HOLD_CYCLES(8), .SCAN_CYCLES(4)) dut (
    .clk          (clk),
    .reset_cpu    (reset_cpu),
    .wwd_valid    (wwd_valid),
    .wwd_data     (wwd_data),
    .wwd_ready    (wwd_ready),
    .pc_below8bit (pc_below8bit),
    .led          (led),
    .seg          (seg),
    .an           (an),
    .shown_value  (shown_value),
    .pending      (pending),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every change of shown_value must be the next accepted value.
  always @(negedge clk) begin
    if (mon_en && shown_value !== last_shown) begin
      last_shown = shown_value;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got %h expected none", shown_value);
      end else begin
        chk("sb_order", {16'h0, shown_value}, {16'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    logic [15:0] prev;
    logic [1:0]  idx;
    logic [2:0]  exp_p [7];
    logic        exp_r [7];
    logic        exp_o [7];
    logic [15:0] exp_v;

    vecs[0].val = 16'h1234; vecs[0].segs = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    vecs[1].val = 16'h5678; vecs[1].segs = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
    vecs[2].val = 16'h9ABC; vecs[2].segs = {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110};
    vecs[3].val = 16'hDEF0; vecs[3].segs = {7'b0100001, 7'b0000110, 7'b0001110, 7'b1000000};

    reset_cpu = 1'b1; wwd_valid = 1'b0; wwd_data = '0; pc_below8bit = '0;
    step(2);

    // Reset state
    chk("rst_shown", {16'h0, shown_value}, 32'h0);
    chk("rst_pending", {29'h0, pending}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_ready", {31'h0, wwd_ready}, 32'h1);
    reset_cpu = 1'b0;
    mon_en = 1'b1;

    // Idle scan: digit changes every 4 clocks, all glyphs "0"
    for (int k = 0; k < 20; k++) begin
      chk("idle_an", {28'h0, an}, {28'h0, ~(4'b0001 << ((k / 4) % 4))});
      chk("idle_seg", {25'h0, seg}, {25'h0, 7'b1000000});
      step(1);
    end

    // Table: single strobe latency and per-digit decode
    prev = 16'h0000;
    for (int v = 0; v < 4; v++) begin
      wwd_valid = 1'b1; wwd_data = vecs[v].val;
      sb.push_back(vecs[v].val);
      step(1);
      wwd_valid = 1'b0;
      chk("lat_t1_shown", {16'h0, shown_value}, {16'h0, prev});
      chk("lat_t1_pending", {29'h0, pending}, 32'h1);
      step(1);
      chk("lat_t2_shown", {16'h0, shown_value}, {16'h0, vecs[v].val});
      chk("lat_t2_pending", {29'h0, pending}, 32'h0);
      step(1);
      for (int c = 0; c < 16; c++) begin
        case (an)
          4'b1110: idx = 2'd0;
          4'b1101: idx = 2'd1;
          4'b1011: idx = 2'd2;
          4'b0111: idx = 2'd3;
          default: begin
            idx = 2'd0;
            chk("scan_an_onehot", {28'h0, an}, 32'hE);
          end
        endcase
        chk("digit_seg", {25'h0, seg}, {25'h0, vecs[v].segs[idx]});
        step(1);
      end
      prev = vecs[v].val;
    end

    // Three strobes back-to-back: each shown exactly 8 clocks
    for (int i = 1; i <= 3; i++) begin
      wwd_valid = 1'b1; wwd_data = 16'(i);
      sb.push_back(16'(i));
      step(1);
      if (i == 3) chk("b2b_pending_peak", {29'h0, pending}, 32'h2);
    end
    wwd_valid = 1'b0;
    // now just after edge e3
    for (int k = 3; k < 30; k++) begin
      exp_v = (k < 10) ? 16'h0001 : (k < 18) ? 16'h0002 : 16'h0003;
      chk("b2b_shown", {16'h0, shown_value}, {16'h0, exp_v});
      step(1);
    end
    chk("b2b_drained", {29'h0, pending}, 32'h0);

    // Overflow: BEEF then AAA0..AAA5 on consecutive clocks
    exp_p = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    exp_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      wwd_valid = 1'b1;
      wwd_data  = (i == 0) ? 16'hBEEF : 16'hAAA0 + 16'(i - 1);
      if (i < 5) sb.push_back(wwd_data);
      step(1);
      chk("ovf_pending", {29'h0, pending}, {29'h0, exp_p[i]});
      chk("ovf_ready", {31'h0, wwd_ready}, {31'h0, exp_r[i]});
      chk("ovf_flag", {31'h0, overflow}, {31'h0, exp_o[i]});
    end
    wwd_valid = 1'b0;
    step(40);
    chk("ovf_sb_empty", sb.size(), 32'h0);
    chk("ovf_last_shown", {16'h0, shown_value}, 32'hAAA3);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Simultaneous push and pop at pending=2
    for (int i = 1; i <= 3; i++) begin
      wwd_valid = 1'b1; wwd_data = 16'h1111 * 16'(i);
      sb.push_back(wwd_data);
      step(1);
    end
    wwd_valid = 1'b0;
    step(6);
    chk("pp_pending_before", {29'h0, pending}, 32'h2);
    chk("pp_shown_before", {16'h0, shown_value}, 32'h1111);
    wwd_valid = 1'b1; wwd_data = 16'h4444;
    sb.push_back(16'h4444);
    step(1);
    wwd_valid = 1'b0;
    chk("pp_pending_after", {29'h0, pending}, 32'h2);
    chk("pp_shown_after", {16'h0, shown_value}, 32'h2222);
    step(30);
    chk("pp_sb_empty", sb.size(), 32'h0);
    chk("pp_last_shown", {16'h0, shown_value}, 32'h4444);

    // Reset mid-HOLD with pending=3; strobe during reset must be ignored
    for (int i = 1; i <= 4; i++) begin
      wwd_valid = 1'b1; wwd_data = 16'h5000 + 16'(i);
      sb.push_back(wwd_data);
      step(1);
    end
    chk("mr_pending_pre", {29'h0, pending}, 32'h3);
    mon_en = 1'b0;
    reset_cpu = 1'b1; wwd_valid = 1'b1; wwd_data = 16'hDEAD;
    step(1);
    reset_cpu = 1'b0; wwd_valid = 1'b0;
    sb.delete();
    last_shown = 16'h0000;
    mon_en = 1'b1;
    chk("mr_pending", {29'h0, pending}, 32'h0);
    chk("mr_shown", {16'h0, shown_value}, 32'h0);
    chk("mr_overflow", {31'h0, overflow}, 32'h0);
    chk("mr_an", {28'h0, an}, 32'hE);
    chk("mr_seg", {25'h0, seg}, {25'h0, 7'b1000000});
    step(6);
    chk("mr_no_store_pending", {29'h0, pending}, 32'h0);
    chk("mr_no_store_shown", {16'h0, shown_value}, 32'h0);

    // LED mirror: one clock behind pc_below8bit
    prev = 16'h0000;
    for (int i = 0; i < 28; i++) begin
      pc_below8bit = 8'(i);
      chk("led_hold", {24'h0, led}, {16'h0, prev});
      step(1);
      chk("led_follow", {24'h0, led}, 32'(i));
      prev = 16'(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
